// File: rtl/sme_host.sv
// Host-side initiator for the string-match engine: buffers one string and one
// pattern, streams them on request and captures the engine's result.
module sme_host #(
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       send_str,
  input  logic       start,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       timeout
);

  localparam int SAW = $clog2(STR_DEPTH);
  localparam int PAW = $clog2(PAT_DEPTH);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, DONE} state_t;

  logic [7:0] str_mem [STR_DEPTH];
  logic [7:0] pat_mem [PAT_DEPTH];

  state_t         state_q, state_d;
  logic [SAW-1:0] idx_q, idx_d, idx_nx;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     slen_q, slen_d, str_clamp;
  logic [3:0]     plen_q, plen_d;
  logic [7:0]     chardata_q, chardata_d;
  logic           isstring_q, isstring_d;
  logic           ispattern_q, ispattern_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           res_match_q, res_match_d;
  logic [4:0]     res_index_q, res_index_d;
  logic           timeout_q, timeout_d;
  logic           pat_ok;

  // Buffers are never reset; writes are blocked while a request streams.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      if (wr_sel) pat_mem[wr_addr[PAW-1:0]] <= wr_data;
      else        str_mem[wr_addr[SAW-1:0]] <= wr_data;
    end
  end

  assign str_clamp = (str_len > 6'(STR_DEPTH)) ? 6'(STR_DEPTH) : str_len;
  assign pat_ok    = (pat_len != 4'd0) && (pat_len <= 4'(PAT_DEPTH));
  assign idx_nx    = idx_q + 1'b1;

  // Outputs are registered, so each branch computes the values for the
  // state being entered, not the current one.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    slen_d      = slen_q;
    plen_d      = plen_q;
    chardata_d  = '0;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && pat_ok) begin
          slen_d    = str_clamp;
          plen_d    = pat_len;
          timeout_d = 1'b0;
          idx_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          if (send_str && (str_len != 6'd0)) begin
            state_d    = SEND_STR;
            isstring_d = 1'b1;
            chardata_d = str_mem[0];
          end else begin
            state_d     = SEND_PAT;
            ispattern_d = 1'b1;
            chardata_d  = pat_mem[0];
          end
        end
      end
      SEND_STR: begin
        if (6'(idx_q) == slen_q - 6'd1) begin
          state_d     = SEND_PAT;
          idx_d       = '0;
          ispattern_d = 1'b1;
          chardata_d  = pat_mem[0];
        end else begin
          idx_d      = idx_nx;
          isstring_d = 1'b1;
          chardata_d = str_mem[idx_nx];
        end
      end
      SEND_PAT: begin
        if (4'(idx_q) == plen_q - 4'd1) begin
          state_d = WAIT;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          idx_d       = idx_nx;
          ispattern_d = 1'b1;
          chardata_d  = pat_mem[idx_nx[PAW-1:0]];
        end
      end
      WAIT: begin
        // A result arriving on the last allowed cycle still counts.
        if (valid) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          res_match_d = match;
          res_index_d = match_index;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          res_match_d = 1'b0;
          res_index_d = '0;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      slen_q      <= '0;
      plen_q      <= '0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      slen_q      <= slen_d;
      plen_q      <= plen_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy      = busy_q;
  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign done      = done_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sme_host.sv
// Directed + randomized bench for sme_host against a queue-based stream model.
module tb_sme_host;
  localparam int TMO = 255;

  logic       clk, reset, wr_en, wr_sel, send_str, start, valid, match;
  logic [4:0] wr_addr, match_index, res_index;
  logic [7:0] wr_data, chardata;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       busy, isstring, ispattern, done, res_match, timeout;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0] str_m [32];
  logic [7:0] pat_m [8];

  sme_host dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .str_len(str_len), .pat_len(pat_len), .send_str(send_str),
    .start(start), .busy(busy), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match), .match_index(match_index),
    .done(done), .res_match(res_match), .res_index(res_index), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input bit sel, input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a[4:0]; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel) pat_m[a[2:0]] = d;
    else     str_m[a[4:0]] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_qual"}, {isstring, ispattern, chardata}, 0);
  endtask

  // valid_at: WAIT cycle (1-based) on which valid is presented; <=0 means never.
  task automatic run_req(input bit snd, input int slen, input int plen, input int valid_at,
                         input bit m, input logic [4:0] mi, input bit busy_wr);
    logic [9:0] exp_q[$];
    int n, k, exp_k;
    bit tmo;
    n = (snd && slen != 0) ? ((slen > 32) ? 32 : slen) : 0;
    for (int i = 0; i < n; i++)    exp_q.push_back({2'b10, str_m[i]});
    for (int i = 0; i < plen; i++) exp_q.push_back({2'b01, pat_m[i]});
    str_len = slen[5:0]; pat_len = plen[3:0]; send_str = snd; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on", busy, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 0 && busy_wr) begin
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 5'd0; wr_data = ~pat_m[0];
      end
      chk($sformatf("stream[%0d]", i), {isstring, ispattern, chardata}, exp_q[i]);
      tick();
      wr_en = 1'b0;
    end
    chk("wait_qual", {isstring, ispattern, chardata}, 0);
    chk("wait_busy", busy, 1);
    tmo   = !(valid_at >= 1 && valid_at <= TMO);
    exp_k = tmo ? TMO : valid_at;
    k = 1;
    while (k <= 400) begin
      if (k == valid_at) begin valid = 1'b1; match = m; match_index = mi; end
      tick();
      valid = 1'b0;
      if (done) break;
      k++;
    end
    chk("done_latency", k, exp_k);
    chk("done_busy", busy, 0);
    chk("res_match", res_match, tmo ? 0 : m);
    chk("res_index", res_index, tmo ? 0 : mi);
    chk("timeout", timeout, tmo);
    tick();
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    string s;
    reset = 1'b1; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; str_len = 0;
    pat_len = 0; send_str = 0; start = 0; valid = 0; match = 0; match_index = 0;
    #12;
    check_idle_outputs("reset");
    chk("reset_res", {res_match, res_index, timeout}, 0);
    @(posedge clk); #1; reset = 1'b0;
    tick();

    // Basic string + pattern request
    s = "abcdefgh";
    for (int i = 0; i < 8; i++) load(0, i, s[i]);
    s = "cde";
    for (int i = 0; i < 3; i++) load(1, i, s[i]);
    run_req(1, 8, 3, 3, 1'b1, 5'd2, 0);

    // Pattern-only resend
    s = "xy";
    for (int i = 0; i < 2; i++) load(1, i, s[i]);
    run_req(0, 8, 2, 1, 1'b0, 5'd7, 0);

    // Illegal pattern lengths are ignored
    foreach (pat_len[i]) ;
    for (int pl = 0; pl <= 9; pl += 9) begin
      pat_len = pl[3:0]; str_len = 6'd8; send_str = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        check_idle_outputs($sformatf("badlen%0d", pl));
        tick();
      end
    end

    // Timeout, then valid in IDLE has no effect
    run_req(1, 4, 2, 0, 1'b1, 5'd9, 0);
    valid = 1'b1; match = 1'b1; match_index = 5'd17;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_idle_outputs("idle_valid");
      chk("idle_valid_res", {res_match, res_index, timeout}, {1'b0, 5'd0, 1'b1});
    end
    valid = 1'b0;

    // Reset mid-string, then resend from index 0 with a blocked busy write
    s = "abcdefgh";
    for (int i = 0; i < 8; i++) load(0, i, s[i]);
    s = "cde";
    for (int i = 0; i < 3; i++) load(1, i, s[i]);
    str_len = 6'd8; pat_len = 4'd3; send_str = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("pre_reset_char4", {isstring, ispattern, chardata}, {2'b10, str_m[4]});
    #1 reset = 1'b1;
    #1;
    chk("async_isstring", isstring, 0);
    chk("async_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    check_idle_outputs("post_reset");
    run_req(1, 8, 3, 2, 1'b1, 5'd5, 1);
    run_req(0, 0, 3, 1, 1'b0, 5'd0, 0);

    // Clamped string length, valid coincident with the timeout cycle
    for (int i = 0; i < 32; i++) load(0, i, 8'($urandom));
    for (int i = 0; i < 8; i++) load(1, i, 8'($urandom));
    run_req(1, 40, 5, TMO, 1'b1, 5'd31, 0);

    // Randomized requests
    for (int r = 0; r < 6; r++) begin
      int va;
      for (int i = 0; i < 32; i++) load(0, i, 8'($urandom));
      for (int i = 0; i < 8; i++) load(1, i, 8'($urandom));
      va = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 30));
      run_req(bit'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
              int'($urandom_range(1, 8)), va, bit'($urandom_range(0, 1)),
              5'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sme_host.md
Name: sme_host

Overview:
- Initiator side of the string-match engine interface: it buffers one string (up to 32 chars) and one pattern (up to 8 chars) loaded by a controller.
- On start it streams them as chardata qualified by isstring/ispattern, then waits for the engine's valid and captures match/match_index.
- Sits between the system controller (or the test harness) and the match engine. It lets patterns be re-sent against a previously sent string without resending the string.

Parameters:
- STR_DEPTH, 32, string buffer entries (max string length).
- PAT_DEPTH, 8, pattern buffer entries (max pattern length).
- TIMEOUT, 255, WAIT-state cycles allowed before abandoning a request.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  buffer write strobe; ignored while busy=1.
- wr_sel  in  1  0 = string buffer, 1 = pattern buffer.
- wr_addr  in  5  write index; pattern writes use wr_addr[2:0].
- wr_data  in  8  character to write.
- str_len  in  6  string length, sampled at start.
- pat_len  in  4  pattern length, sampled at start.
- send_str  in  1  sampled at start; 1 = send the string phase before the pattern.
- start  in  1  request pulse.
- busy  out  1  high from the cycle after an accepted start until done.
- chardata  out  8  character to the engine.
- isstring  out  1  chardata is a string character.
- ispattern  out  1  chardata is a pattern character.
- valid  in  1  engine result strobe.
- match  in  1  engine match flag.
- match_index  in  5  engine match position.
- done  out  1  one-cycle completion pulse.
- res_match  out  1  captured match.
- res_index  out  5  captured match_index.
- timeout  out  1  set when the request ended without valid; held until the next accepted start.

Behaviour:
- Reset values: all outputs 0, state IDLE, indices and counter 0. Buffer contents are not cleared.
- All outputs are registered.
- States: IDLE, SEND_STR, SEND_PAT, WAIT, DONE.
- IDLE:
  - start is accepted when pat_len is 1..8; otherwise it is ignored (no busy, no done).
  - On accept, latch lengths and send_str, clear timeout, and go to SEND_STR if send_str=1 and str_len!=0, else SEND_PAT.
  - str_len>32 is clamped to 32.
- Latency: the first character appears on chardata, with its qualifier, in the cycle after the start edge.
- SEND_STR:
  - One character per cycle, with isstring=1, ispattern=0, chardata=str[idx], idx from 0.
  - After str_len cycles, go directly to SEND_PAT with no gap cycle.
- SEND_PAT:
  - One character per cycle, with ispattern=1, isstring=0, chardata=pat[idx].
  - After pat_len cycles, go to WAIT.
  - isstring and ispattern are never both 1.
- WAIT:
  - chardata=0, isstring=0, ispattern=0.
  - valid is sampled only in WAIT; valid in any other state is ignored.
  - On valid=1: res_match<=match, res_index<=match_index, go to DONE.
  - The cycle counter increments each WAIT cycle. When it reaches TIMEOUT without valid: res_match<=0, res_index<=0, timeout<=1, go to DONE.
  - valid in the same cycle the counter hits TIMEOUT: valid wins, timeout stays 0.
- DONE:
  - done=1 for exactly one cycle, busy=0 in this cycle, then go to IDLE.
  - res_match, res_index and timeout hold until the next accepted start.
- start while busy is ignored. wr_en while busy is ignored, so buffers are stable during streaming.
- Reset mid-operation: qualifiers drop to 0 immediately (asynchronous), busy=0, no done pulse. The next start re-sends from index 0.
- Result latency: from the start edge, 1 + N + M cycles until WAIT, where N is the string length (0 if skipped) and M is the pattern length.

Test Plan:
- Load string "abcdefgh" (8), pattern "cde" (3), send_str=1, start: isstring high for 8 consecutive cycles with chardata 0x61..0x68, then ispattern high for 3 cycles with 0x63,0x64,0x65, no gap. Engine valid with match=1, match_index=2 -> res_match=1, res_index=2, done pulses once.
- Second request with send_str=0, pattern "xy": no isstring cycles, ispattern high for 2 cycles. Valid with match=0 -> res_match=0, done pulse.
- pat_len=0 start, and pat_len=9 start: busy stays 0, no qualifiers, no done.
- Valid never arrives, TIMEOUT=255: done arrives 255 WAIT cycles after entry, with timeout=1, res_match=0, res_index=0. Valid held high in IDLE afterwards has no effect.
- Assert reset during SEND_STR at character 4: isstring=0 immediately, busy=0. After release, start re-sends from character 0. wr_en during busy does not alter pat[0].
- str_len=40: exactly 32 isstring cycles. Valid coincident with the timeout cycle -> timeout=0 and the result is captured.
